// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchronises a raw input, debounces it, and
// produces a registered level plus one-cycle rise/fall pulses.
module debounce_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic pulse_rise,
  output logic pulse_fall,
  output logic busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    DEB_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    DEB_LOW   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   level_next;
  logic                   rise_next;
  logic                   fall_next;
  logic                   busy_next;

  assign sync = sync_chain[SYNC_STAGES-1];

  // Plain flop chain bringing the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_in};
    end
  end

  // Next-state logic: a candidate level must hold for STABLE_CYCLES samples;
  // any sample agreeing with the current level abandons the candidate.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync) begin
          if (STABLE_CYCLES == 1) begin
            state_next = IDLE_HIGH;
            level_next = 1'b1;
            rise_next  = 1'b1;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = DEB_HIGH;
            cnt_next   = CNT_ONE;
          end
        end else begin
          cnt_next = CNT_ZERO;
        end
      end
      DEB_HIGH: begin
        if (!sync) begin
          state_next = IDLE_LOW;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_HIGH;
          level_next = 1'b1;
          rise_next  = 1'b1;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync) begin
          if (STABLE_CYCLES == 1) begin
            state_next = IDLE_LOW;
            level_next = 1'b0;
            fall_next  = 1'b1;
            cnt_next   = CNT_ZERO;
          end else begin
            state_next = DEB_LOW;
            cnt_next   = CNT_ONE;
          end
        end else begin
          cnt_next = CNT_ZERO;
        end
      end
      DEB_LOW: begin
        if (sync) begin
          state_next = IDLE_HIGH;
          cnt_next   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE_LOW;
          level_next = 1'b0;
          fall_next  = 1'b1;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = CNT_ZERO;
        level_next = 1'b0;
      end
    endcase
    busy_next = (state_next == DEB_HIGH) || (state_next == DEB_LOW);
  end

  // State and fully registered outputs; pulses self-clear every edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE_LOW;
      cnt        <= CNT_ZERO;
      level      <= 1'b0;
      pulse_rise <= 1'b0;
      pulse_fall <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      level      <= level_next;
      pulse_rise <= rise_next;
      pulse_fall <= fall_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse: default and STABLE_CYCLES=1 instances side by side,
// compared every cycle against a run-length reference model.
module tb_debounce_pulse;

  logic clock = 1'b0;
  logic reset;
  logic btn_in;
  logic level_a, pulse_rise_a, pulse_fall_a, busy_a;
  logic level_b, pulse_rise_b, pulse_fall_b, busy_b;

  always #5 clock = ~clock;

  debounce_pulse u_def (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .level(level_a), .pulse_rise(pulse_rise_a), .pulse_fall(pulse_fall_a), .busy(busy_a)
  );

  debounce_pulse #(.SYNC_STAGES(2), .STABLE_CYCLES(1)) u_fast (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .level(level_b), .pulse_rise(pulse_rise_b), .pulse_fall(pulse_fall_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: sync delay line, then count consecutive samples that
  // disagree with the accepted level; accept once the run reaches the limit.
  logic dq[$];
  int   run[2];
  int   stab[2];
  logic ml[2], mpr[2], mpf[2], mb[2];
  int   rises_a, falls_a;
  logic [1:0] cnt2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic b, input logic r);
    logic s;
    btn_in = b;
    reset  = r;
    @(posedge clock);
    s = dq.pop_front();
    dq.push_back(b);
    if (r) begin
      dq = '{1'b0, 1'b0};
      for (int k = 0; k < 2; k++) begin
        run[k] = 0; ml[k] = 1'b0; mpr[k] = 1'b0; mpf[k] = 1'b0; mb[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mpr[k] = 1'b0;
        mpf[k] = 1'b0;
        if (s !== ml[k]) begin
          run[k]++;
          if (run[k] >= stab[k]) begin
            ml[k]  = s;
            mpr[k] = s;
            mpf[k] = ~s;
            run[k] = 0;
          end
        end else begin
          run[k] = 0;
        end
        mb[k] = (run[k] > 0);
      end
    end
    #1;
    chk("level_def", level_a, ml[0]);
    chk("rise_def", pulse_rise_a, mpr[0]);
    chk("fall_def", pulse_fall_a, mpf[0]);
    chk("busy_def", busy_a, mb[0]);
    chk("level_fast", level_b, ml[1]);
    chk("rise_fast", pulse_rise_b, mpr[1]);
    chk("fall_fast", pulse_fall_b, mpf[1]);
    chk("busy_fast", busy_b, mb[1]);
    if (pulse_rise_a === 1'b1) begin
      rises_a++;
      cnt2 = cnt2 + 2'd1;
    end else begin
      rises_a = rises_a;
    end
    if (pulse_fall_a === 1'b1) falls_a++;
  endtask

  initial begin
    int len;
    logic v;
    stab[0] = 4;
    stab[1] = 1;
    dq = '{1'b0, 1'b0};
    rises_a = 0;
    falls_a = 0;
    cnt2 = 2'd0;

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_level", level_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);

    // Clean press: pulse after edge 6 (edge 3 for the fast instance)
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      if (i == 3) chk("fast_rise_edge3", pulse_rise_b, 1'b1);
      if (i >= 3 && i <= 5) chk("busy_edges3to5", busy_a, 1'b1);
      if (i == 5) chk("no_rise_edge5", pulse_rise_a, 1'b0);
      if (i == 6) chk("rise_edge6", pulse_rise_a, 1'b1);
      if (i == 7) chk("rise_one_cycle", pulse_rise_a, 1'b0);
    end
    chk("press_level", level_a, 1'b1);
    chk("press_rises", rises_a, 1);
    chk("press_no_fall", falls_a, 0);

    // Release
    rises_a = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0);
      if (i == 6) chk("fall_edge6", pulse_fall_a, 1'b1);
    end
    chk("release_level", level_a, 1'b0);
    chk("release_no_rise", rises_a, 0);

    // Glitch shorter than qualification
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk("glitch_rises", rises_a, 0);
    chk("glitch_level", level_a, 1'b0);
    chk("glitch_busy", busy_a, 1'b0);

    // Bounce 1,0,1,1,0,1 then held high
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    for (int i = 2; i <= 12; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) chk("bounce_rise_edge6", pulse_rise_a, 1'b1);
    end
    chk("bounce_rises", rises_a, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Reset during qualification with the button still held
    rises_a = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_mid_rises", rises_a, 0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0);
      if (i == 6) chk("reset_rise_edge6", pulse_rise_a, 1'b1);
    end
    chk("reset_rises", rises_a, 1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // Five clean presses into a 2-bit counter wrap to 1
    cnt2 = 2'd0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    end
    chk("counter_wrap", cnt2, 2'b01);

    // Random bouncing segments
    for (int seg = 0; seg < 80; seg++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) step(v, 1'b0);
      if ($urandom_range(0, 19) == 0) step(v, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
